id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Parametrised RV32I decode stage: integer-ALU subset decode, operand selection, N-channel forwarding, load-use stall detection.
- Registered ID/EX output with valid/ready handshake; absorbs the separate ID_EX latch.
- Sits between IF/ID and EX; drives the register-file read ports combinationally.

Parameters:
- FWD_CH, 3, number of forwarding channels; channel 0 = youngest producer, highest priority.
- XLEN, 32, data/address width.
- REG_IDX_W, 5, register index width.
- INST_IDX_W, 6, width of instIdx_out.
- INST_TYPE_W, 3, width of instType_out.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-low.
- if_valid_in  in  1  pc_in/inst_in valid.
- if_ready_out  out  1  ID accepts the instruction this cycle.
- pc_in  in  XLEN  instruction PC.
- inst_in  in  32  instruction word.
- reg1E_out, reg2E_out  out  1 each  regfile read enables (combinational).
- reg1Idx_out, reg2Idx_out  out  REG_IDX_W each  regfile read indices (combinational).
- reg1Data_in, reg2Data_in  in  XLEN each  regfile read data.
- fwdE_in  in  FWD_CH  channel k holds a register write.
- fwdPend_in  in  FWD_CH  channel k value not yet available (load in flight).
- fwdIdx_in  in  FWD_CH*REG_IDX_W  destination index, packed, channel k at [k*W +: W].
- fwdData_in  in  FWD_CH*XLEN  result data, packed.
- flush_in  in  1  kill the registered and the incoming instruction.
- ex_ready_in  in  1  EX accepts.
- ex_valid_out  out  1  registered output valid.
- rdE_out, rdIdx_out, instIdx_out, instType_out, rs1Data_out, rs2Data_out, imm_out, pc_out, illegal_out  out  registered  decoded bundle to EX.

Behaviour:
- Reset (rst_in=0, async): ex_valid_out=0; all registered outputs 0 (idNOP, typeNOP, regNOP).
- Decode (combinational):
  - Opcodes: LUI, AUIPC, OP-IMM (ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI), OP (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND).
  - I-imm is sign-extended; shift-imm is zero-extended inst[24:20]; U-imm is {inst[31:12],12'b0}.
  - Illegal encodings (unknown opcode; funct7 not 0000000, or not 0100000 for SUB/SRA/SRAI):
    - decode as idNOP, rdE=0, read enables 0, illegal_out=1;
    - still pass through the handshake.
  - rd==0 forces rdE=0.
- Operand select, per source:
  - AUIPC: rs1 = pc_in, rs2 = imm.
  - Read-disabled source: value = imm (LUI: rs1 = imm, rs2 = imm).
  - Read-enabled source with index 0: value 0; no forwarding match is possible.
  - Otherwise, lowest k with fwdE_in[k] && fwdIdx_in[k]==idx supplies fwdData_in[k].
  - No channel matches: value = regfile data.
- Hazard: the selected matching channel has fwdPend_in=1. Lower-priority channels never override a pending younger match.
- Handshake:
  - out_free = !ex_valid_out || ex_ready_in.
  - if_ready_out = out_free && !hazard && !flush_in.
  - Accept = if_valid_in && if_ready_out; the decoded bundle is captured at the next edge, latency 1 cycle.
  - Output holds stable while ex_valid_out && !ex_ready_in.
  - Consumed with no new accept: ex_valid_out -> 0.
  - Hazard with out_free: inserts a bubble (ex_valid_out=0); the instruction is held upstream and re-evaluated every cycle.
- flush_in=1: ex_valid_out -> 0 next edge and no accept, regardless of ex_ready_in or hazard. Flush has priority over the load.
- Reset mid-stall: the bundle is lost and ex_valid_out=0 immediately (async).

Decomposition:
- Shared package, extended from the existing defines: opcode/funct3/funct7 constants, idXXX/typeXXX encodings (now including ADD, SUB, shifts), regNOP, ZERO, read/write enable levels.
- One sub-module, id_operand_sel, instantiated twice (rs1, rs2). It holds the priority forwarding mux plus pending detection and outputs value and hazard.

Test Plan:
- ADDI x5,x0,-3 (0xFFD00293), ex_ready_in=1 -> next cycle ex_valid_out=1, idADD, rdIdx=5, rs1=0, rs2=0xFFFFFFFD, illegal_out=0.
- ADD x3,x1,x2 with ch0{E,idx1,0x11}, ch2{E,idx1,0x33}, ch1{E,idx2,0x22}, regfile 0x99 -> rs1=0x11, rs2=0x22.
- Same ADD with ch0{E,pend,idx2} -> if_ready_out=0, bubble emitted; drop pend with data 0x55 -> accepted next cycle, rs2=0x55.
- ex_ready_in=0 for 3 cycles with valid output -> bundle stable, if_ready_out=0; raise ready -> next instruction captured in the same edge.
- Instruction word 0x0000007F -> ex_valid_out=1, illegal_out=1, rdE=0; inst with rs1=x0 and ch0{E,idx0,0xAB} -> rs1=0.
- flush_in during held output and pending upstream -> ex_valid_out=0 next cycle, no accept; rst_in low mid-stall -> outputs 0 asynchronously.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared RV32I decode constants: opcodes, funct fields, operation/type encodings
// and enable levels used by the decode stage and its operand selectors.
package id_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Register-immediate forms share the ALU operation id with their register forms.
    typedef enum logic [5:0] {
        ID_NOP   = 6'd0,
        ID_ADD   = 6'd1,
        ID_SUB   = 6'd2,
        ID_SLL   = 6'd3,
        ID_SLT   = 6'd4,
        ID_SLTU  = 6'd5,
        ID_XOR   = 6'd6,
        ID_SRL   = 6'd7,
        ID_SRA   = 6'd8,
        ID_OR    = 6'd9,
        ID_AND   = 6'd10,
        ID_LUI   = 6'd11,
        ID_AUIPC = 6'd12
    } inst_id_e;

    typedef enum logic [2:0] {
        TYPE_NOP = 3'd0,
        TYPE_R   = 3'd1,
        TYPE_I   = 3'd2,
        TYPE_U   = 3'd3
    } inst_type_e;

    localparam logic [4:0]  REG_NOP = 5'd0;
    localparam logic [31:0] ZERO    = 32'd0;

    localparam logic RD_EN  = 1'b1;
    localparam logic RD_DIS = 1'b0;
    localparam logic WR_EN  = 1'b1;
    localparam logic WR_DIS = 1'b0;

endpackage

// File: rtl/id_stage_if.sv
// Bus bundle around the decode stage: IF/ID handshake, regfile read ports,
// forwarding channels and the registered ID/EX bundle.
interface id_stage_if #(
    parameter int FWD_CH      = 3,
    parameter int XLEN        = 32,
    parameter int REG_IDX_W   = 5,
    parameter int INST_IDX_W  = 6,
    parameter int INST_TYPE_W = 3
);
    logic                        if_valid_in;
    logic                        if_ready_out;
    logic [XLEN-1:0]             pc_in;
    logic [31:0]                 inst_in;
    logic                        reg1E_out;
    logic                        reg2E_out;
    logic [REG_IDX_W-1:0]        reg1Idx_out;
    logic [REG_IDX_W-1:0]        reg2Idx_out;
    logic [XLEN-1:0]             reg1Data_in;
    logic [XLEN-1:0]             reg2Data_in;
    logic [FWD_CH-1:0]           fwdE_in;
    logic [FWD_CH-1:0]           fwdPend_in;
    logic [FWD_CH*REG_IDX_W-1:0] fwdIdx_in;
    logic [FWD_CH*XLEN-1:0]      fwdData_in;
    logic                        flush_in;
    logic                        ex_ready_in;
    logic                        ex_valid_out;
    logic                        rdE_out;
    logic [REG_IDX_W-1:0]        rdIdx_out;
    logic [INST_IDX_W-1:0]       instIdx_out;
    logic [INST_TYPE_W-1:0]      instType_out;
    logic [XLEN-1:0]             rs1Data_out;
    logic [XLEN-1:0]             rs2Data_out;
    logic [XLEN-1:0]             imm_out;
    logic [XLEN-1:0]             pc_out;
    logic                        illegal_out;

    // Decode stage view.
    modport slave (
        input  if_valid_in, pc_in, inst_in, reg1Data_in, reg2Data_in,
               fwdE_in, fwdPend_in, fwdIdx_in, fwdData_in, flush_in, ex_ready_in,
        output if_ready_out, reg1E_out, reg2E_out, reg1Idx_out, reg2Idx_out,
               ex_valid_out, rdE_out, rdIdx_out, instIdx_out, instType_out,
               rs1Data_out, rs2Data_out, imm_out, pc_out, illegal_out
    );

    // Surrounding pipeline view (fetch, regfile, forwarding network, EX).
    modport master (
        output if_valid_in, pc_in, inst_in, reg1Data_in, reg2Data_in,
               fwdE_in, fwdPend_in, fwdIdx_in, fwdData_in, flush_in, ex_ready_in,
        input  if_ready_out, reg1E_out, reg2E_out, reg1Idx_out, reg2Idx_out,
               ex_valid_out, rdE_out, rdIdx_out, instIdx_out, instType_out,
               rs1Data_out, rs2Data_out, imm_out, pc_out, illegal_out
    );

endinterface

// File: rtl/id_operand_sel.sv
// One source operand: priority forwarding mux (channel 0 = youngest) with
// load-use detection on the selected channel.
module id_operand_sel #(
    parameter int FWD_CH    = 3,
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                        rd_en,
    input  logic [REG_IDX_W-1:0]        idx,
    input  logic [XLEN-1:0]             rf_data,
    input  logic [XLEN-1:0]             alt_data,
    input  logic [FWD_CH-1:0]           fwd_e,
    input  logic [FWD_CH-1:0]           fwd_pend,
    input  logic [FWD_CH*REG_IDX_W-1:0] fwd_idx,
    input  logic [FWD_CH*XLEN-1:0]      fwd_data,
    output logic [XLEN-1:0]             value,
    output logic                        hazard
);

    logic found_s;

    // Once the youngest matching channel is found, older channels cannot override it.
    always_comb begin
        value   = rf_data;
        hazard  = 1'b0;
        found_s = 1'b0;
        if (!rd_en) begin
            value = alt_data;
        end else if (idx == {REG_IDX_W{1'b0}}) begin
            value = {XLEN{1'b0}};
        end else begin
            for (int k = 0; k < FWD_CH; k++) begin
                if (!found_s && fwd_e[k] && (fwd_idx[k*REG_IDX_W +: REG_IDX_W] == idx)) begin
                    found_s = 1'b1;
                    value   = fwd_data[k*XLEN +: XLEN];
                    hazard  = fwd_pend[k];
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I integer-ALU decode stage with operand forwarding, load-use stall and a
// registered ID/EX bundle behind a valid/ready handshake.
module id_stage #(
    parameter int FWD_CH      = 3,
    parameter int XLEN        = 32,
    parameter int REG_IDX_W   = 5,
    parameter int INST_IDX_W  = 6,
    parameter int INST_TYPE_W = 3
) (
    input  logic       clk_in,
    input  logic       rst_in,
    id_stage_if.slave  bus
);
    import id_stage_pkg::*;

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rd_field_s;
    logic [4:0]      rs1_field_s;
    logic [4:0]      rs2_field_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_sh_s;
    logic [XLEN-1:0] imm_u_s;

    inst_id_e        dec_id_s;
    inst_type_e      dec_type_s;
    logic            dec_rd_en_s;
    logic [4:0]      dec_rd_idx_s;
    logic            dec_rs1_en_s;
    logic            dec_rs2_en_s;
    logic            dec_illegal_s;
    logic            dec_auipc_s;
    logic [XLEN-1:0] dec_imm_s;

    logic [XLEN-1:0] rs1_alt_s;
    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    logic            rs1_haz_s;
    logic            rs2_haz_s;
    logic            hazard_s;
    logic            out_free_s;
    logic            if_ready_s;
    logic            accept_s;

    logic                   ex_valid_r;
    logic                   rd_en_r;
    logic [REG_IDX_W-1:0]   rd_idx_r;
    logic [INST_IDX_W-1:0]  inst_idx_r;
    logic [INST_TYPE_W-1:0] inst_type_r;
    logic [XLEN-1:0]        rs1_data_r;
    logic [XLEN-1:0]        rs2_data_r;
    logic [XLEN-1:0]        imm_r;
    logic [XLEN-1:0]        pc_r;
    logic                   illegal_r;

    assign opcode_s    = bus.inst_in[6:0];
    assign rd_field_s  = bus.inst_in[11:7];
    assign funct3_s    = bus.inst_in[14:12];
    assign rs1_field_s = bus.inst_in[19:15];
    assign rs2_field_s = bus.inst_in[24:20];
    assign funct7_s    = bus.inst_in[31:25];

    assign imm_i_s  = XLEN'($signed(bus.inst_in[31:20]));
    assign imm_sh_s = XLEN'(bus.inst_in[24:20]);
    assign imm_u_s  = XLEN'($signed({bus.inst_in[31:12], 12'b0}));

    // Instruction decode; any illegal encoding collapses to a NOP bundle.
    always_comb begin
        dec_id_s      = ID_NOP;
        dec_type_s    = TYPE_NOP;
        dec_rd_en_s   = WR_DIS;
        dec_rd_idx_s  = rd_field_s;
        dec_rs1_en_s  = RD_DIS;
        dec_rs2_en_s  = RD_DIS;
        dec_illegal_s = 1'b0;
        dec_auipc_s   = 1'b0;
        dec_imm_s     = {XLEN{1'b0}};
        case (opcode_s)
            OPC_LUI: begin
                dec_id_s    = ID_LUI;
                dec_type_s  = TYPE_U;
                dec_rd_en_s = WR_EN;
                dec_imm_s   = imm_u_s;
            end
            OPC_AUIPC: begin
                dec_id_s    = ID_AUIPC;
                dec_type_s  = TYPE_U;
                dec_rd_en_s = WR_EN;
                dec_imm_s   = imm_u_s;
                dec_auipc_s = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_type_s   = TYPE_I;
                dec_rd_en_s  = WR_EN;
                dec_rs1_en_s = RD_EN;
                dec_imm_s    = imm_i_s;
                case (funct3_s)
                    F3_ADD:  dec_id_s = ID_ADD;
                    F3_SLT:  dec_id_s = ID_SLT;
                    F3_SLTU: dec_id_s = ID_SLTU;
                    F3_XOR:  dec_id_s = ID_XOR;
                    F3_OR:   dec_id_s = ID_OR;
                    F3_AND:  dec_id_s = ID_AND;
                    F3_SLL: begin
                        dec_imm_s = imm_sh_s;
                        if (funct7_s == F7_BASE) dec_id_s = ID_SLL;
                        else dec_illegal_s = 1'b1;
                    end
                    F3_SR: begin
                        dec_imm_s = imm_sh_s;
                        if (funct7_s == F7_BASE) dec_id_s = ID_SRL;
                        else if (funct7_s == F7_ALT) dec_id_s = ID_SRA;
                        else dec_illegal_s = 1'b1;
                    end
                    default: dec_illegal_s = 1'b1;
                endcase
            end
            OPC_OP: begin
                dec_type_s   = TYPE_R;
                dec_rd_en_s  = WR_EN;
                dec_rs1_en_s = RD_EN;
                dec_rs2_en_s = RD_EN;
                if (funct7_s == F7_BASE) begin
                    case (funct3_s)
                        F3_ADD:  dec_id_s = ID_ADD;
                        F3_SLL:  dec_id_s = ID_SLL;
                        F3_SLT:  dec_id_s = ID_SLT;
                        F3_SLTU: dec_id_s = ID_SLTU;
                        F3_XOR:  dec_id_s = ID_XOR;
                        F3_SR:   dec_id_s = ID_SRL;
                        F3_OR:   dec_id_s = ID_OR;
                        F3_AND:  dec_id_s = ID_AND;
                        default: dec_illegal_s = 1'b1;
                    endcase
                end else if (funct7_s == F7_ALT) begin
                    case (funct3_s)
                        F3_ADD:  dec_id_s = ID_SUB;
                        F3_SR:   dec_id_s = ID_SRA;
                        default: dec_illegal_s = 1'b1;
                    endcase
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            default: dec_illegal_s = 1'b1;
        endcase

        if (dec_illegal_s) begin
            dec_id_s     = ID_NOP;
            dec_type_s   = TYPE_NOP;
            dec_rd_en_s  = WR_DIS;
            dec_rd_idx_s = REG_NOP;
            dec_rs1_en_s = RD_DIS;
            dec_rs2_en_s = RD_DIS;
            dec_auipc_s  = 1'b0;
            dec_imm_s    = {XLEN{1'b0}};
        end else if (rd_field_s == REG_NOP) begin
            dec_rd_en_s = WR_DIS;
        end else begin
            dec_rd_en_s = dec_rd_en_s;
        end
    end

    assign bus.reg1E_out   = dec_rs1_en_s;
    assign bus.reg2E_out   = dec_rs2_en_s;
    assign bus.reg1Idx_out = dec_rs1_en_s ? REG_IDX_W'(rs1_field_s) : REG_IDX_W'(REG_NOP);
    assign bus.reg2Idx_out = dec_rs2_en_s ? REG_IDX_W'(rs2_field_s) : REG_IDX_W'(REG_NOP);

    assign rs1_alt_s = dec_auipc_s ? bus.pc_in : dec_imm_s;

    id_operand_sel #(.FWD_CH(FWD_CH), .XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_sel_rs1 (
        .rd_en    (dec_rs1_en_s),
        .idx      (bus.reg1Idx_out),
        .rf_data  (bus.reg1Data_in),
        .alt_data (rs1_alt_s),
        .fwd_e    (bus.fwdE_in),
        .fwd_pend (bus.fwdPend_in),
        .fwd_idx  (bus.fwdIdx_in),
        .fwd_data (bus.fwdData_in),
        .value    (rs1_val_s),
        .hazard   (rs1_haz_s)
    );

    id_operand_sel #(.FWD_CH(FWD_CH), .XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_sel_rs2 (
        .rd_en    (dec_rs2_en_s),
        .idx      (bus.reg2Idx_out),
        .rf_data  (bus.reg2Data_in),
        .alt_data (dec_imm_s),
        .fwd_e    (bus.fwdE_in),
        .fwd_pend (bus.fwdPend_in),
        .fwd_idx  (bus.fwdIdx_in),
        .fwd_data (bus.fwdData_in),
        .value    (rs2_val_s),
        .hazard   (rs2_haz_s)
    );

    assign hazard_s   = rs1_haz_s | rs2_haz_s;
    assign out_free_s = !ex_valid_r || bus.ex_ready_in;
    assign if_ready_s = out_free_s && !hazard_s && !bus.flush_in;
    assign accept_s   = bus.if_valid_in && if_ready_s;

    // ID/EX register: flush kills, accept loads, consume without accept empties, else hold.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ex_valid_r  <= 1'b0;
            rd_en_r     <= WR_DIS;
            rd_idx_r    <= REG_IDX_W'(REG_NOP);
            inst_idx_r  <= INST_IDX_W'(ID_NOP);
            inst_type_r <= INST_TYPE_W'(TYPE_NOP);
            rs1_data_r  <= XLEN'(ZERO);
            rs2_data_r  <= XLEN'(ZERO);
            imm_r       <= XLEN'(ZERO);
            pc_r        <= XLEN'(ZERO);
            illegal_r   <= 1'b0;
        end else if (bus.flush_in) begin
            ex_valid_r <= 1'b0;
        end else if (accept_s) begin
            ex_valid_r  <= 1'b1;
            rd_en_r     <= dec_rd_en_s;
            rd_idx_r    <= REG_IDX_W'(dec_rd_idx_s);
            inst_idx_r  <= INST_IDX_W'(dec_id_s);
            inst_type_r <= INST_TYPE_W'(dec_type_s);
            rs1_data_r  <= rs1_val_s;
            rs2_data_r  <= rs2_val_s;
            imm_r       <= dec_imm_s;
            pc_r        <= bus.pc_in;
            illegal_r   <= dec_illegal_s;
        end else if (bus.ex_ready_in) begin
            ex_valid_r <= 1'b0;
        end else begin
            ex_valid_r <= ex_valid_r;
        end
    end

    assign bus.if_ready_out = if_ready_s;
    assign bus.ex_valid_out = ex_valid_r;
    assign bus.rdE_out      = rd_en_r;
    assign bus.rdIdx_out    = rd_idx_r;
    assign bus.instIdx_out  = inst_idx_r;
    assign bus.instType_out = inst_type_r;
    assign bus.rs1Data_out  = rs1_data_r;
    assign bus.rs2Data_out  = rs2_data_r;
    assign bus.imm_out      = imm_r;
    assign bus.pc_out       = pc_r;
    assign bus.illegal_out  = illegal_r;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a decode vector table plus hand-written
// stall, back-pressure, flush and reset sequences.
module tb_id_stage;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [2:0]  fe;
        logic [2:0]  fp;
        logic [14:0] fidx;
        logic [95:0] fdata;
        logic [5:0]  id;
        logic [2:0]  ty;
        logic        rde;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        ill;
        logic        re1;
        logic        re2;
    } vec_t;

    localparam int NVEC = 12;

    logic clk_s   = 1'b0;
    logic rst_n_s = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [NVEC];

    id_stage_if bus ();

    id_stage dut (
        .clk_in (clk_s),
        .rst_in (rst_n_s),
        .bus    (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk_s = ~clk_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [2:0] fe, input logic [2:0] fp,
                         input logic [14:0] fidx, input logic [95:0] fdata);
        bus.inst_in     = inst;
        bus.pc_in       = pc;
        bus.reg1Data_in = r1;
        bus.reg2Data_in = r2;
        bus.fwdE_in     = fe;
        bus.fwdPend_in  = fp;
        bus.fwdIdx_in   = fidx;
        bus.fwdData_in  = fdata;
    endtask

    initial begin
        // inst, pc, r1, r2, fe, fp, fidx, fdata | id, type, rdE, rd, rs1, rs2, imm, illegal, re1, re2
        vecs[0]  = '{32'hFFD00293, 32'h100, 32'h77, 32'h0, 3'b000, 3'b000, 15'h0, 96'h0,
                     6'd1, 3'd2, 1'b1, 5'd5, 32'h0, 32'hFFFFFFFD, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'h002081B3, 32'h104, 32'h99, 32'h99, 3'b111, 3'b000,
                     {5'd1, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11},
                     6'd1, 3'd1, 1'b1, 5'd3, 32'h11, 32'h22, 32'h0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{32'h40208233, 32'h108, 32'h100, 32'h20, 3'b000, 3'b000, 15'h0, 96'h0,
                     6'd2, 3'd1, 1'b1, 5'd4, 32'h100, 32'h20, 32'h0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{32'h123453B7, 32'h10C, 32'hDEAD, 32'hBEEF, 3'b000, 3'b000, 15'h0, 96'h0,
                     6'd11, 3'd3, 1'b1, 5'd7, 32'h12345000, 32'h12345000, 32'h12345000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'hFFFFF417, 32'h400, 32'h1, 32'h2, 3'b000, 3'b000, 15'h0, 96'h0,
                     6'd12, 3'd3, 1'b1, 5'd8, 32'h400, 32'hFFFFF000, 32'hFFFFF000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h40755493, 32'h110, 32'hF0, 32'h3, 3'b000, 3'b000, 15'h0, 96'h0,
                     6'd8, 3'd2, 1'b1, 5'd9, 32'hF0, 32'h7, 32'h7, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{32'h02755493, 32'h114, 32'hF0, 32'h3, 3'b000, 3'b000, 15'h0, 96'h0,
                     6'd0, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000007F, 32'h118, 32'h5, 32'h6, 3'b000, 3'b000, 15'h0, 96'h0,
                     6'd0, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'h00200333, 32'h11C, 32'h99, 32'h5, 3'b001, 3'b000, 15'h0, {64'h0, 32'hAB},
                     6'd1, 3'd1, 1'b1, 5'd6, 32'h0, 32'h5, 32'h0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{32'h00108033, 32'h120, 32'h7, 32'h7, 3'b000, 3'b000, 15'h0, 96'h0,
                     6'd1, 3'd1, 1'b0, 5'd0, 32'h7, 32'h7, 32'h0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{32'hFFF63593, 32'h124, 32'h3, 32'h0, 3'b000, 3'b000, 15'h0, 96'h0,
                     6'd5, 3'd2, 1'b1, 5'd11, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{32'h002081B3, 32'h128, 32'h99, 32'h9, 3'b011, 3'b010,
                     {5'd0, 5'd1, 5'd1}, {32'h0, 32'hEE, 32'h44},
                     6'd1, 3'd1, 1'b1, 5'd3, 32'h44, 32'h9, 32'h0, 1'b0, 1'b1, 1'b1};

        bus.if_valid_in = 1'b0;
        bus.flush_in    = 1'b0;
        bus.ex_ready_in = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 15'h0, 96'h0);

        // Reset state.
        #12;
        chk("rst_valid", 32'(bus.ex_valid_out), 32'd0);
        chk("rst_id", 32'(bus.instIdx_out), 32'd0);
        chk("rst_type", 32'(bus.instType_out), 32'd0);
        chk("rst_rd", 32'(bus.rdIdx_out), 32'd0);
        chk("rst_rs1", bus.rs1Data_out, 32'd0);
        chk("rst_illegal", 32'(bus.illegal_out), 32'd0);
        @(negedge clk_s);
        rst_n_s = 1'b1;
        step();

        // Decode table, one accepted instruction per cycle.
        bus.if_valid_in = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].inst, vecs[i].pc, vecs[i].r1, vecs[i].r2,
                  vecs[i].fe, vecs[i].fp, vecs[i].fidx, vecs[i].fdata);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.if_ready_out), 32'd1);
            chk($sformatf("v%0d_re1", i), 32'(bus.reg1E_out), 32'(vecs[i].re1));
            chk($sformatf("v%0d_re2", i), 32'(bus.reg2E_out), 32'(vecs[i].re2));
            step();
            chk($sformatf("v%0d_valid", i), 32'(bus.ex_valid_out), 32'd1);
            chk($sformatf("v%0d_id", i), 32'(bus.instIdx_out), 32'(vecs[i].id));
            chk($sformatf("v%0d_type", i), 32'(bus.instType_out), 32'(vecs[i].ty));
            chk($sformatf("v%0d_rde", i), 32'(bus.rdE_out), 32'(vecs[i].rde));
            chk($sformatf("v%0d_rd", i), 32'(bus.rdIdx_out), 32'(vecs[i].rd));
            chk($sformatf("v%0d_rs1", i), bus.rs1Data_out, vecs[i].rs1);
            chk($sformatf("v%0d_rs2", i), bus.rs2Data_out, vecs[i].rs2);
            chk($sformatf("v%0d_imm", i), bus.imm_out, vecs[i].imm);
            chk($sformatf("v%0d_illegal", i), 32'(bus.illegal_out), 32'(vecs[i].ill));
            chk($sformatf("v%0d_pc", i), bus.pc_out, vecs[i].pc);
        end

        // Load-use: pending youngest match on rs2 stalls and emits bubbles.
        drive(32'h002081B3, 32'h200, 32'h61, 32'h62, 3'b001, 3'b001, {5'd0, 5'd0, 5'd2}, {64'h0, 32'h55});
        #1;
        chk("haz_ready0", 32'(bus.if_ready_out), 32'd0);
        step();
        chk("haz_bubble0", 32'(bus.ex_valid_out), 32'd0);
        chk("haz_ready1", 32'(bus.if_ready_out), 32'd0);
        step();
        chk("haz_bubble1", 32'(bus.ex_valid_out), 32'd0);
        bus.fwdPend_in = 3'b000;
        #1;
        chk("haz_release_ready", 32'(bus.if_ready_out), 32'd1);
        step();
        chk("haz_valid", 32'(bus.ex_valid_out), 32'd1);
        chk("haz_rs1", bus.rs1Data_out, 32'h61);
        chk("haz_rs2", bus.rs2Data_out, 32'h55);

        // Back-pressure: bundle holds for three cycles, then the next one loads on the same edge.
        bus.ex_ready_in = 1'b0;
        drive(32'h40208233, 32'h204, 32'h100, 32'h70, 3'b000, 3'b000, 15'h0, 96'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_ready", c), 32'(bus.if_ready_out), 32'd0);
            step();
            chk($sformatf("bp%0d_valid", c), 32'(bus.ex_valid_out), 32'd1);
            chk($sformatf("bp%0d_id", c), 32'(bus.instIdx_out), 32'd1);
            chk($sformatf("bp%0d_rs2", c), bus.rs2Data_out, 32'h55);
            chk($sformatf("bp%0d_pc", c), bus.pc_out, 32'h200);
        end
        bus.ex_ready_in = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.if_ready_out), 32'd1);
        step();
        chk("bp_next_valid", 32'(bus.ex_valid_out), 32'd1);
        chk("bp_next_id", 32'(bus.instIdx_out), 32'd2);
        chk("bp_next_rs2", bus.rs2Data_out, 32'h70);

        // Flush while output is held and upstream is stalled on a pending load.
        bus.ex_ready_in = 1'b0;
        drive(32'h002081B3, 32'h208, 32'h61, 32'h62, 3'b001, 3'b001, {5'd0, 5'd0, 5'd2}, {64'h0, 32'h55});
        bus.flush_in = 1'b1;
        #1;
        chk("fl_ready", 32'(bus.if_ready_out), 32'd0);
        step();
        chk("fl_valid", 32'(bus.ex_valid_out), 32'd0);
        bus.flush_in = 1'b0;
        step();
        chk("fl_no_accept", 32'(bus.ex_valid_out), 32'd0);

        // Reset asserted mid-stall drops the held bundle immediately.
        bus.fwdPend_in = 3'b000;
        step();
        chk("rs_loaded", 32'(bus.ex_valid_out), 32'd1);
        bus.fwdPend_in = 3'b001;
        step();
        chk("rs_held", 32'(bus.ex_valid_out), 32'd1);
        #2;
        rst_n_s = 1'b0;
        #1;
        chk("rs_async_valid", 32'(bus.ex_valid_out), 32'd0);
        chk("rs_async_id", 32'(bus.instIdx_out), 32'd0);
        chk("rs_async_rs1", bus.rs1Data_out, 32'd0);
        chk("rs_async_pc", bus.pc_out, 32'd0);
        @(negedge clk_s);
        rst_n_s = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
